// File: rtl/axil_drop_ctrl_regs_if.sv
// AXI4-Lite control bus between the shell crossbar and the drop-control register block.
interface axil_drop_ctrl_regs_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_drop_ctrl_regs.sv
// AXI4-Lite register block: drop enable, scratch register, and saturating
// packet / dropped-packet counters fed by a monitored AXI-Stream tap.
module axil_drop_ctrl_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic                         axil_aclk,
  input  logic                         axil_aresetn,
  axil_drop_ctrl_regs_if.slave         s_axil,
  input  logic                         mon_tvalid,
  input  logic                         mon_tready,
  input  logic                         mon_tlast,
  output logic                         drop_en
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] OFS_CTRL    = 2'd0;
  localparam logic [1:0] OFS_SCRATCH = 2'd1;
  localparam logic [1:0] OFS_PKT     = 2'd2;
  localparam logic [1:0] OFS_DROP    = 2'd3;

  w_state_e    w_state, w_next;
  r_state_e    r_state, r_next;
  logic [31:0] aw_addr_q, w_data_q;
  logic [31:0] scratch_q, pkt_cnt_q, drop_cnt_q;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        wr_fire, wr_in_win, ctrl_wr, cnt_clear, beat;
  logic [31:0] wr_addr, wr_data;
  logic        rd_in_win;
  logic [31:0] rd_value;

  // Byte-lane bits of the addresses are deliberately ignored by the decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0], aw_addr_q[1:0]};

  assign aw_hs = s_axil.awvalid & s_axil.awready;
  assign w_hs  = s_axil.wvalid  & s_axil.wready;
  assign b_hs  = s_axil.bvalid  & s_axil.bready;
  assign ar_hs = s_axil.arvalid & s_axil.arready;
  assign r_hs  = s_axil.rvalid  & s_axil.rready;
  assign beat  = mon_tvalid & mon_tready & mon_tlast;

  // Address/data come from the latch when that half arrived earlier, else from the bus.
  assign wr_addr   = (w_state == W_HAVE_AW) ? aw_addr_q : s_axil.awaddr;
  assign wr_data   = (w_state == W_HAVE_W)  ? w_data_q  : s_axil.wdata;
  assign wr_fire   = (w_state != W_RESP) && (aw_hs || w_state == W_HAVE_AW)
                                         && (w_hs  || w_state == W_HAVE_W);
  assign wr_in_win = (wr_addr[31:4] == BASE_ADDR[31:4]);
  assign ctrl_wr   = wr_fire && wr_in_win && (wr_addr[3:2] == OFS_CTRL);
  assign cnt_clear = ctrl_wr && wr_data[1];

  // Write FSM next state.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_next = W_RESP;
      W_HAVE_W:  if (aw_hs) w_next = W_RESP;
      W_RESP:    if (b_hs)  w_next = W_IDLE;
      default:              w_next = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!axil_aresetn) w_state <= W_IDLE;
    else               w_state <= w_next;
  end

  // Write channel handshake outputs, latches and response.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
    end else begin
      s_axil.awready <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
      s_axil.wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
      s_axil.bvalid  <= (w_next == W_RESP);
      if (aw_hs)   aw_addr_q    <= s_axil.awaddr;
      if (w_hs)    w_data_q     <= s_axil.wdata;
      if (wr_fire) s_axil.bresp <= wr_in_win ? RESP_OKAY : RESP_DECERR;
    end
  end

  // Writable registers; counter slots are silently read-only.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      drop_en   <= 1'b0;
      scratch_q <= '0;
    end else if (wr_fire && wr_in_win) begin
      if (wr_addr[3:2] == OFS_CTRL)    drop_en   <= wr_data[0];
      if (wr_addr[3:2] == OFS_SCRATCH) scratch_q <= wr_data;
    end
  end

  // Saturating counters; a clear beats a same-cycle increment.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (cnt_clear) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (beat) begin
      if (pkt_cnt_q != '1)             pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (drop_en && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  // Read data mux from current register values; out-of-window reads return 0.
  assign rd_in_win = (s_axil.araddr[31:4] == BASE_ADDR[31:4]);
  always_comb begin
    rd_value = '0;
    if (rd_in_win) begin
      unique case (s_axil.araddr[3:2])
        OFS_CTRL:    rd_value = {31'd0, drop_en};
        OFS_SCRATCH: rd_value = scratch_q;
        OFS_PKT:     rd_value = pkt_cnt_q;
        OFS_DROP:    rd_value = drop_cnt_q;
        default:     rd_value = '0;
      endcase
    end
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (r_hs)  r_next = R_IDLE;
      default:            r_next = R_IDLE;
    endcase
  end

  // Read FSM state register, handshake outputs and held read data.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_state        <= R_IDLE;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rdata   <= '0;
      s_axil.rresp   <= RESP_OKAY;
    end else begin
      r_state        <= r_next;
      s_axil.arready <= (r_next == R_IDLE);
      s_axil.rvalid  <= (r_next == R_RESP);
      if (ar_hs) begin
        s_axil.rdata <= rd_value;
        s_axil.rresp <= rd_in_win ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_drop_ctrl_regs.sv
// Self-checking bench for axil_drop_ctrl_regs: bus tasks feed a response
// scoreboard, feature tasks check side-band behaviour inline.
module tb_axil_drop_ctrl_regs;

  logic axil_aclk = 1'b0;
  logic axil_aresetn = 1'b0;
  logic mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic drop_en;

  always #5 axil_aclk = ~axil_aclk;

  axil_drop_ctrl_regs_if bus ();

  axil_drop_ctrl_regs #(.BASE_ADDR(32'h0000_1000)) dut (
    .axil_aclk    (axil_aclk),
    .axil_aresetn (axil_aresetn),
    .s_axil       (bus),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .drop_en      (drop_en)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t rd_exp_q[$];
  exp_t wr_exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the register file.
  logic        m_drop_en = 1'b0;
  logic [31:0] m_scratch = '0, m_pkt = '0, m_drop = '0;

  localparam int TIMEOUT = 50;

  // Read one register; the returned beat is scored against the oldest expectation.
  task automatic axil_read(input string name, input logic [31:0] addr);
    int   t;
    exp_t e;
    @(negedge axil_aclk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    bus.arvalid = 1'b0;
    t = 0;
    while (!bus.rvalid && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    e = rd_exp_q.pop_front();
    n_cmp++;
    if (!bus.rvalid || bus.rdata !== e.data || bus.rresp !== e.resp) begin
      n_bad++;
      $display("FAIL %s: rvalid=%b rdata=%h rresp=%b, expected rdata=%h rresp=%b",
               name, bus.rvalid, bus.rdata, bus.rresp, e.data, e.resp);
    end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
  endtask

  // Write with AW and W together; bready held low for 'hold' cycles after bvalid should rise.
  task automatic axil_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input int hold, input bit beat, output int held);
    int   t;
    exp_t e;
    @(negedge axil_aclk);
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = (hold == 0);
    if (beat) begin mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1; end
    t = 0;
    while (!(bus.awready && bus.wready) && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    held = 0;
    for (int i = 0; i < hold; i++) begin
      if (bus.bvalid) held++;
      @(negedge axil_aclk);
    end
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    e = wr_exp_q.pop_front();
    n_cmp++;
    if (!bus.bvalid || bus.bresp !== e.resp) begin
      n_bad++;
      $display("FAIL %s: bvalid=%b bresp=%b, expected bvalid=1 bresp=%b",
               name, bus.bvalid, bus.bresp, e.resp);
    end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge axil_aclk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, drop_en} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: aw/w/ar/b/r/drop=%b, expected 000000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, drop_en});
    end
    n_cmp++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h, expected zeros",
               bus.bresp, bus.rresp, bus.rdata);
    end
    axil_aresetn = 1'b1;
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_release_ready: aw/w/ar=%b, expected 111",
               {bus.awready, bus.wready, bus.arready});
    end
    rd_exp_q.push_back('{32'd0, 2'b00}); axil_read("reset_ctrl_rd",    32'h1000);
    rd_exp_q.push_back('{32'd0, 2'b00}); axil_read("reset_scratch_rd", 32'h1004);
    rd_exp_q.push_back('{32'd0, 2'b00}); axil_read("reset_pkt_rd",     32'h1008);
    rd_exp_q.push_back('{32'd0, 2'b00}); axil_read("reset_drop_rd",    32'h100C);
  endtask

  // AW first, then W alone: response and drop_en land on the edge after the W handshake.
  task automatic test_ctrl_write();
    int t;
    @(negedge axil_aclk);
    bus.awaddr  = 32'h1000;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    bus.awvalid = 1'b0;
    n_cmp++;
    if ({bus.awready, bus.wready, bus.bvalid, drop_en} !== 4'b0100) begin
      n_bad++;
      $display("FAIL ctrl_have_aw: aw/w/b/drop=%b, expected 0100",
               {bus.awready, bus.wready, bus.bvalid, drop_en});
    end
    bus.wdata  = 32'h1;
    bus.wvalid = 1'b1;
    t = 0;
    while (!bus.wready && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    bus.wvalid = 1'b0;
    m_drop_en = 1'b1;
    n_cmp++;
    if ({bus.bvalid, bus.bresp, drop_en} !== {1'b1, 2'b00, m_drop_en}) begin
      n_bad++;
      $display("FAIL ctrl_bvalid_latency: bvalid=%b bresp=%b drop_en=%b, expected 1 00 1",
               bus.bvalid, bus.bresp, drop_en);
    end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    n_cmp++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      n_bad++;
      $display("FAIL ctrl_after_b: bvalid/aw/w=%b, expected 011",
               {bus.bvalid, bus.awready, bus.wready});
    end
    rd_exp_q.push_back('{{31'd0, m_drop_en}, 2'b00}); axil_read("ctrl_rd", 32'h1000);
  endtask

  // Three two-beat packets; the second one's last beat stalls on tready for 5 cycles.
  task automatic test_counting();
    bit last;
    int stall;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        last  = (b == 1);
        stall = (p == 1 && last) ? 5 : 0;
        @(negedge axil_aclk);
        mon_tvalid = 1'b1;
        mon_tlast  = last;
        mon_tready = (stall == 0);
        repeat (stall) @(negedge axil_aclk);
        mon_tready = 1'b1;
        if (last) begin
          m_pkt++;
          if (m_drop_en) m_drop++;
        end
      end
    end
    @(negedge axil_aclk);
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    rd_exp_q.push_back('{m_pkt,  2'b00}); axil_read("pkt_cnt_rd",  32'h1008);
    rd_exp_q.push_back('{m_drop, 2'b00}); axil_read("drop_cnt_rd", 32'h100C);
  endtask

  task automatic test_scratch_backpressure();
    int held;
    wr_exp_q.push_back('{32'd0, 2'b00});
    axil_write("scratch_wr", 32'h1004, 32'hA5A5_5A5A, 4, 1'b0, held);
    m_scratch = 32'hA5A5_5A5A;
    n_cmp++;
    if (held !== 4) begin
      n_bad++;
      $display("FAIL bvalid_hold: held %0d cycles, expected 4", held);
    end
    rd_exp_q.push_back('{m_scratch, 2'b00}); axil_read("scratch_rd", 32'h1004);
    wr_exp_q.push_back('{32'd0, 2'b00});
    axil_write("pkt_cnt_wr", 32'h1008, 32'hDEAD_BEEF, 0, 1'b0, held);
    rd_exp_q.push_back('{m_pkt, 2'b00}); axil_read("pkt_cnt_ro_rd", 32'h1008);
    // Byte-lane bits of the address must not affect the decode.
    rd_exp_q.push_back('{m_scratch, 2'b00}); axil_read("scratch_lsb_rd", 32'h1007);
  endtask

  // Counter clear lands on the same edge as a counted tlast beat.
  task automatic test_clear_collision();
    int held;
    wr_exp_q.push_back('{32'd0, 2'b00});
    axil_write("clear_wr", 32'h1000, 32'h2, 0, 1'b1, held);
    m_pkt = '0; m_drop = '0; m_drop_en = 1'b0;
    n_cmp++;
    if (drop_en !== m_drop_en) begin
      n_bad++;
      $display("FAIL clear_drop_en: drop_en=%b, expected %b", drop_en, m_drop_en);
    end
    rd_exp_q.push_back('{m_pkt,  2'b00}); axil_read("clear_pkt_rd",  32'h1008);
    rd_exp_q.push_back('{m_drop, 2'b00}); axil_read("clear_drop_rd", 32'h100C);
    rd_exp_q.push_back('{32'd0,  2'b00}); axil_read("clear_ctrl_rd", 32'h1000);
  endtask

  task automatic test_decerr();
    int held;
    rd_exp_q.push_back('{32'd0, 2'b11}); axil_read("oow_rd", 32'h2000);
    wr_exp_q.push_back('{32'd0, 2'b11});
    axil_write("oow_wr_0ffc", 32'h0FFC, 32'hFFFF_FFFF, 0, 1'b0, held);
    wr_exp_q.push_back('{32'd0, 2'b11});
    axil_write("oow_wr_0ff0", 32'h0FF0, 32'h1, 0, 1'b0, held);
    n_cmp++;
    if (drop_en !== m_drop_en) begin
      n_bad++;
      $display("FAIL oow_drop_en: drop_en=%b, expected %b", drop_en, m_drop_en);
    end
    rd_exp_q.push_back('{m_scratch, 2'b00}); axil_read("oow_scratch_rd", 32'h1004);
    rd_exp_q.push_back('{32'd0,     2'b00}); axil_read("oow_ctrl_rd",    32'h1000);
  endtask

  // Reset while holding only the write address.
  task automatic test_reset_mid();
    int held;
    int t;
    wr_exp_q.push_back('{32'd0, 2'b00});
    axil_write("pre_reset_ctrl_wr", 32'h1000, 32'h1, 0, 1'b0, held);
    m_drop_en = 1'b1;
    @(negedge axil_aclk);
    bus.awaddr  = 32'h1004;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < TIMEOUT) begin @(negedge axil_aclk); t++; end
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    bus.awvalid = 1'b0;
    n_cmp++;
    if ({bus.awready, bus.wready, drop_en} !== 3'b011) begin
      n_bad++;
      $display("FAIL pre_reset_state: aw/w/drop=%b, expected 011",
               {bus.awready, bus.wready, drop_en});
    end
    axil_aresetn = 1'b0;
    #1;
    m_drop_en = 1'b0; m_scratch = '0; m_pkt = '0; m_drop = '0;
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, drop_en} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_reset: aw/w/ar/b/drop=%b, expected 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, drop_en});
    end
    repeat (2) @(negedge axil_aclk);
    axil_aresetn = 1'b1;
    @(posedge axil_aclk);
    @(negedge axil_aclk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, drop_en} !== 5'b11100) begin
      n_bad++;
      $display("FAIL post_reset: aw/w/ar/b/drop=%b, expected 11100",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, drop_en});
    end
    rd_exp_q.push_back('{m_scratch, 2'b00}); axil_read("post_reset_scratch_rd", 32'h1004);
    rd_exp_q.push_back('{32'd0,     2'b00}); axil_read("post_reset_ctrl_rd",    32'h1000);
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0;
    bus.bready  = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b1;
    test_reset();
    test_ctrl_write();
    test_counting();
    test_scratch_backpressure();
    test_clear_collision();
    test_decerr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_drop_ctrl_regs.md
# axil_drop_ctrl_regs

AXI4-Lite responder that terminates the shell's control-register writes and reads, and exposes the packet-drop enable to the datapath. It also counts packets completed on a monitored AXI-Stream interface and packets completed while drop is enabled, so that software and benches can confirm drop behaviour by register read. It sits on the AXI-Lite control bus inside the user box, between the shell's AXI-Lite crossbar and the packet-filter datapath.

## Interface
- `BASE_ADDR`, 32'h0000_1000: base of the 16-byte register window.
- `axil_aclk`  in  1  single clock for all logic; monitor inputs are already in this domain.
- `axil_aresetn`  in  1  asynchronous, active-low reset.
- `s_axil_awvalid` / `s_axil_awready`  in/out  1  write address handshake.
- `s_axil_awaddr`  in  32  write byte address.
- `s_axil_wvalid` / `s_axil_wready`  in/out  1  write data handshake.
- `s_axil_wdata`  in  32  write data; always a full-word write, no strobes.
- `s_axil_bvalid` / `s_axil_bready`  out/in  1  write response handshake.
- `s_axil_bresp`  out  2  write response code.
- `s_axil_arvalid` / `s_axil_arready`  in/out  1  read address handshake.
- `s_axil_araddr`  in  32  read byte address.
- `s_axil_rvalid` / `s_axil_rready`  out/in  1  read data handshake.
- `s_axil_rdata`  out  32  read data.
- `s_axil_rresp`  out  2  read response code.
- `mon_tvalid`, `mon_tready`, `mon_tlast`  in  1 each  taps of the monitored AXI-Stream.
- `drop_en`  out  1  drop enable to the datapath; equals CTRL[0].

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0 CTRL, RW. Bit 0 is drop_en, reset 0. Bit 1 is write-1 counter clear, self-clearing and always read as 0. Bits 31:2 read 0.
  - 0x4 SCRATCH, RW, 32 bits, reset 0.
  - 0x8 PKT_CNT, RO. Increments when `mon_tvalid & mon_tready & mon_tlast`.
  - 0xC DROP_CNT, RO. Increments under the same condition while `drop_en` is 1.
- Address decode uses `addr[31:4] == BASE_ADDR[31:4]`; `addr[1:0]` is ignored.
  - Outside the window, a write is discarded with resp 2'b11 (DECERR), and a read returns 0 with resp 2'b11.
  - A write to PKT_CNT or DROP_CNT is ignored with resp 2'b00.
  - All in-window accesses return resp 2'b00.
- Counters are 32 bits and saturate at 0xFFFF_FFFF.
  - A clear (write of CTRL with bit 1 = 1) zeroes both counters. Clear wins over a same-cycle increment, and the result is 0.
  - The CTRL write that sets bit 0 also takes effect on bit 1 in the same write.
- Write FSM:
  - States: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle. Address and data are latched on their respective handshakes.
  - W_IDLE goes to W_HAVE_AW, W_HAVE_W or W_RESP depending on which handshakes occur. Any W_HAVE_* state goes to W_RESP on the missing handshake.
  - The register update happens on the edge that completes the pair, and bvalid rises on that edge.
  - W_RESP returns to W_IDLE on `bvalid & bready`.
- Read FSM:
  - States: R_IDLE, R_RESP.
  - An AR handshake registers rdata/rresp from register values in the handshake cycle, i.e. before any same-cycle update.
  - R_RESP holds rdata stable until `rvalid & rready`.
- The read and write FSMs are independent. A same-cycle read of a register being written returns the old value.

## Timing
- Reset values: awready, wready, arready, bvalid and rvalid are 0; bresp, rresp and rdata are 0; drop_en is 0; all registers are 0.
- awready, wready and arready are registered. They rise on the first edge after reset release.
- awready is 1 only in W_IDLE and W_HAVE_W. wready is 1 only in W_IDLE and W_HAVE_AW. Each drops on the edge following its handshake.
- arready is 1 only in R_IDLE.
- Write latency: bvalid asserts 1 cycle after the later of the AW and W handshakes. The next AW/W is accepted no earlier than 1 cycle after the B handshake.
- Read latency: rvalid asserts 1 cycle after the AR handshake. Back-to-back reads therefore complete at best every 2 cycles.
- bvalid and rvalid stay asserted under backpressure, with bresp, rresp and rdata held constant.
- drop_en changes on the same edge as bvalid rises for the CTRL write.
- A counter increment is visible to an AR handshake one cycle after the counted beat.
- Reset asserted mid-transaction returns both FSMs to idle immediately. No response is issued for the aborted transaction, and all registers are cleared.

## Test plan
- Write 0x1000 with 1: present AW, drop AW after awready, then present W. Expect bvalid 1 cycle after the W handshake, bresp = 00, and drop_en = 1 on the same edge.
- With drop_en = 1, stream 3 packets with tlast, one stalled by tready = 0 for 5 cycles. Read 0x1008 and expect 3; read 0x100C and expect 3.
- Write 0x1004 with 0xA5A5_5A5A, holding bready = 0 for 4 cycles. Expect bvalid held for those cycles, then read 0x1004 and expect 0xA5A5_5A5A. Write 0x1008 and expect bresp 00 with the counter value unchanged.
- Write 0x1000 with 2 in the same cycle as a counted tlast beat. Expect both counters to be 0, drop_en = 0, and CTRL to read back 0.
- Read 0x2000 and expect rresp = 11, rdata = 0. Write 0x0FFC and expect bresp = 11 with no register change.
- Assert reset while in W_HAVE_AW. Expect bvalid = 0, all readies = 0 during reset and 1 after release, and drop_en = 0.
